// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM port controller.
package sram_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;

   // Top of the 256K-word SRAM; last_addr saturates here naturally.
   localparam logic [17:0] SRAM_ADDR_MAX = 18'h3FFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      W_SETUP = 2'd1,
      W_PULSE = 2'd2,
      W_HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/sram_wr_buffer.sv
// Turns the codec's level write strobe into discrete write events and holds
// one pending event while the FSM is busy with the previous write cycle.
module sram_wr_buffer
   import sram_pkg::*;
#(
   parameter int AW = sram_pkg::ADDR_W,
   parameter int DW = sram_pkg::DATA_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          fsm_idle,
   input  logic          pop,
   output logic          avail,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data,
   output logic          full,
   output logic          wr_overflow
);

   logic          req_q, req_d;
   logic [AW-1:0] seen_addr_q, seen_addr_d;
   logic          full_q, full_d;
   logic [AW-1:0] buf_addr_q, buf_addr_d;
   logic [DW-1:0] buf_data_q, buf_data_d;
   logic          ovf_q, ovf_d;
   logic          evt, drop, push;

   // Event detect, drop decision and buffer next-state. A dropped or
   // cleared event still updates the seen address so a held strobe never
   // re-fires on the same address.
   always_comb begin
      evt  = wr_req && (!req_q || (wr_addr != seen_addr_q));
      drop = evt && !clear && full_q && !fsm_idle;
      push = evt && !clear && !drop;

      // An empty buffer is bypassed so a fresh write starts next cycle.
      avail    = !clear && (full_q || push);
      out_addr = full_q ? buf_addr_q : wr_addr;
      out_data = full_q ? buf_data_q : wr_data;

      req_d       = wr_req;
      seen_addr_d = evt ? wr_addr : seen_addr_q;
      buf_addr_d  = push ? wr_addr : buf_addr_q;
      buf_data_d  = push ? wr_data : buf_data_q;
      ovf_d       = drop;

      full_d = full_q;
      if (clear)
         full_d = 1'b0;
      else if (pop)
         full_d = full_q && push;   // bypassed push is consumed directly
      else if (push)
         full_d = 1'b1;
   end

   // Buffer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q       <= 1'b0;
         seen_addr_q <= '0;
         full_q      <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         req_q       <= req_d;
         seen_addr_q <= seen_addr_d;
         full_q      <= full_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         ovf_q       <= ovf_d;
      end
   end

   assign full        = full_q;
   assign wr_overflow = ovf_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Async SRAM port controller: timed write cycles from codec write events,
// combinational reads while idle, record/playback bookkeeping.
module sram_port_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_W    = sram_pkg::ADDR_W,
   parameter int DATA_W    = sram_pkg::DATA_W,
   parameter int PULSE_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] last_addr,
   output logic              play_done,
   output logic              rd_collision,
   output logic              wr_overflow,
   output logic              busy,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_WE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_CE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] work_addr_q, work_addr_d;
   logic [DATA_W-1:0] work_data_q, work_data_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic              play_q, play_d;
   logic              coll_q, coll_d;
   logic              kill_q, kill_d;
   logic              we_n_q, we_n_d;

   logic              buf_avail, buf_full, pop;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;
   logic              idle;

   assign idle = (state_q == IDLE);

   sram_wr_buffer #(.AW(ADDR_W), .DW(DATA_W)) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .fsm_idle    (idle),
      .pop         (pop),
      .avail       (buf_avail),
      .out_addr    (buf_addr),
      .out_data    (buf_data),
      .full        (buf_full),
      .wr_overflow (wr_overflow)
   );

   // Write-cycle FSM and record bookkeeping next-state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_addr_d = work_addr_q;
      work_data_d = work_data_q;
      last_d      = last_q;
      kill_d      = kill_q;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            // Reads win; a pending write waits for a read-free cycle.
            if (!rd_req && buf_avail) begin
               pop         = 1'b1;
               work_addr_d = buf_addr;
               work_data_d = buf_data;
               kill_d      = 1'b0;
               state_d     = W_SETUP;
            end
         end
         W_SETUP: begin
            cnt_d   = 3'(PULSE_CYC - 1);
            state_d = W_PULSE;
         end
         W_PULSE: begin
            if (cnt_q == 3'd0) state_d = W_HOLD;
            else               cnt_d   = cnt_q - 3'd1;
         end
         W_HOLD: begin
            if (!kill_q && !clear && (work_addr_q > last_q))
               last_d = work_addr_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A clear during a write cycle lets it finish but voids its bookkeeping.
      if (clear && !idle) kill_d = 1'b1;
      if (clear)          last_d = '0;

      play_d = play_q;
      if (clear)
         play_d = 1'b0;
      else if (rd_req && (rd_addr > last_q) && (last_q != '0))
         play_d = 1'b1;

      coll_d = rd_req && !idle;
      we_n_d = (state_d != W_PULSE);
   end

   // All controller state; WE_N is registered so reset lifts it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_addr_q <= '0;
         work_data_q <= '0;
         last_q      <= '0;
         play_q      <= 1'b0;
         coll_q      <= 1'b0;
         kill_q      <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_addr_q <= work_addr_d;
         work_data_q <= work_data_d;
         last_q      <= last_d;
         play_q      <= play_d;
         coll_q      <= coll_d;
         kill_q      <= kill_d;
         we_n_q      <= we_n_d;
      end
   end

   assign SRAM_ADDR    = idle ? rd_addr : work_addr_q;
   assign SRAM_OE_N    = !idle;
   assign SRAM_DQ      = idle ? {DATA_W{1'bz}} : work_data_q;
   assign SRAM_WE_N    = we_n_q;
   assign SRAM_CE_N    = 1'b0;
   assign SRAM_UB_N    = 1'b0;
   assign SRAM_LB_N    = 1'b0;
   assign rd_data      = idle ? SRAM_DQ : '0;
   assign last_addr    = last_q;
   assign play_done    = play_q;
   assign rd_collision = coll_q;
   assign busy         = !idle || buf_full;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a trivial SRAM read model.
module tb_sram_port_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, clear, wr_req, rd_req;
   logic [17:0] wr_addr, rd_addr;
   logic [15:0] wr_data, rd_data;
   logic [17:0] last_addr, SRAM_ADDR;
   logic        play_done, rd_collision, wr_overflow, busy;
   wire  [15:0] SRAM_DQ;
   logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
   logic [15:0] sram_val;

   int n_cmp = 0;
   int n_err = 0;
   int n_we  = 0;
   int ovf_cnt = 0;
   logic [17:0] wa_log [0:31];
   logic [15:0] wd_log [0:31];
   int base;

   always #5 clk = ~clk;

   // SRAM drives the bus whenever its output enable is asserted.
   assign SRAM_DQ = (!SRAM_OE_N) ? sram_val : 16'bz;

   sram_port_ctrl #(.ADDR_W(18), .DATA_W(16), .PULSE_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
      .last_addr(last_addr), .play_done(play_done),
      .rd_collision(rd_collision), .wr_overflow(wr_overflow), .busy(busy),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   // Log every write-pulse cycle (PULSE_CYC = 1 -> one entry per pulse).
   always @(negedge clk) begin
      if (rst_n && !SRAM_WE_N) begin
         if (n_we < 32) begin
            wa_log[n_we] = SRAM_ADDR;
            wd_log[n_we] = SRAM_DQ;
         end
         n_we = n_we + 1;
      end
      if (wr_overflow) ovf_cnt = ovf_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic nxt(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0; sram_val = 16'h0000;
      nxt(2);
      chk("rst_we_n",  32'(SRAM_WE_N), 32'd1);
      chk("rst_oe_n",  32'(SRAM_OE_N), 32'd0);
      chk("rst_ce_ub_lb", {29'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
      chk("rst_last",  32'(last_addr), 32'd0);
      chk("rst_flags", {28'd0, play_done, rd_collision, wr_overflow, busy}, 32'd0);
      rst_n = 1'b1;
      nxt(2);

      // Held strobe, single address: exactly one timed write cycle.
      base = n_we;
      wr_req = 1'b1; wr_addr = 18'd5; wr_data = 16'hA5A5;
      nxt();
      chk("t1_setup_we",   32'(SRAM_WE_N), 32'd1);
      chk("t1_setup_oe",   32'(SRAM_OE_N), 32'd1);
      chk("t1_setup_dq",   32'(SRAM_DQ),   32'hA5A5);
      chk("t1_setup_addr", 32'(SRAM_ADDR), 32'd5);
      nxt();
      chk("t1_pulse_we",   32'(SRAM_WE_N), 32'd0);
      chk("t1_pulse_dq",   32'(SRAM_DQ),   32'hA5A5);
      nxt();
      chk("t1_hold_we",    32'(SRAM_WE_N), 32'd1);
      chk("t1_hold_dq",    32'(SRAM_DQ),   32'hA5A5);
      nxt();
      chk("t1_last",       32'(last_addr), 32'd5);
      chk("t1_idle_oe",    32'(SRAM_OE_N), 32'd0);
      nxt(16);
      chk("t1_pulses",     n_we - base, 1);
      wr_req = 1'b0;
      nxt(2);

      // Back-to-back addresses: second write comes out of the buffer.
      base = n_we;
      wr_req = 1'b1; wr_addr = 18'd7; wr_data = 16'h0007;
      nxt();
      wr_addr = 18'd8; wr_data = 16'h0008;
      nxt(12);
      wr_req = 1'b0;
      chk("t2_pulses", n_we - base, 2);
      chk("t2_addr0",  32'(wa_log[base]),   32'd7);
      chk("t2_addr1",  32'(wa_log[base+1]), 32'd8);
      chk("t2_data1",  32'(wd_log[base+1]), 32'h0008);
      chk("t2_ovf",    ovf_cnt, 0);
      chk("t2_last",   32'(last_addr), 32'd8);
      nxt(2);

      // Idle read is combinational from the SRAM bus.
      sram_val = 16'h1234; rd_req = 1'b1; rd_addr = 18'd5;
      #1;
      chk("t4_rd_data", 32'(rd_data),   32'h1234);
      chk("t4_rd_addr", 32'(SRAM_ADDR), 32'd5);
      nxt();
      rd_req = 1'b0;
      nxt();

      // Read during a write pulse is refused.
      wr_req = 1'b1; wr_addr = 18'd3; wr_data = 16'h0033;
      nxt(2);
      chk("t4_in_pulse", 32'(SRAM_WE_N), 32'd0);
      rd_req = 1'b1; rd_addr = 18'd2;
      #1;
      chk("t4_coll_rd_data", 32'(rd_data), 32'd0);
      nxt();
      rd_req = 1'b0; wr_req = 1'b0;
      chk("t4_coll_pulse", 32'(rd_collision), 32'd1);
      nxt();
      chk("t4_coll_gone",  32'(rd_collision), 32'd0);
      nxt(3);
      chk("t4_last_kept",  32'(last_addr), 32'd8);
      chk("t4_play_clr",   32'(play_done), 32'd0);

      // Read beyond the recording sets play_done until clear.
      rd_req = 1'b1; rd_addr = 18'd9;
      nxt();
      rd_req = 1'b0;
      chk("t5_play_set",  32'(play_done), 32'd1);
      nxt(3);
      chk("t5_play_held", 32'(play_done), 32'd1);
      clear = 1'b1;
      nxt();
      clear = 1'b0;
      chk("t5_play_cleared", 32'(play_done), 32'd0);
      chk("t5_last_cleared", 32'(last_addr), 32'd0);

      // clear coincident with a write event discards the event.
      base = n_we;
      clear = 1'b1; wr_req = 1'b1; wr_addr = 18'd20; wr_data = 16'h2020;
      nxt();
      clear = 1'b0;
      nxt(5);
      chk("t5_clr_evt_pulses", n_we - base, 0);
      chk("t5_clr_evt_busy",   32'(busy), 32'd0);
      wr_req = 1'b0;
      nxt(2);

      // Three addresses in a row: third is dropped with one overflow pulse.
      base = n_we;
      wr_req = 1'b1; wr_addr = 18'd10; wr_data = 16'h000A;
      nxt();
      wr_addr = 18'd11; wr_data = 16'h000B;
      nxt();
      wr_addr = 18'd12; wr_data = 16'h000C;
      nxt();
      wr_req = 1'b0;
      chk("t3_ovf_pulse", 32'(wr_overflow), 32'd1);
      nxt();
      chk("t3_ovf_gone",  32'(wr_overflow), 32'd0);
      nxt(10);
      chk("t3_pulses",  n_we - base, 2);
      chk("t3_addr1",   32'(wa_log[base+1]), 32'd11);
      chk("t3_ovf_cnt", ovf_cnt, 1);
      chk("t3_last",    32'(last_addr), 32'd11);

      // Top address saturates last_addr; a lower write leaves it there.
      wr_req = 1'b1; wr_addr = 18'h3FFFF; wr_data = 16'hBEEF;
      nxt(6);
      wr_req = 1'b0;
      chk("t6_last_max", 32'(last_addr), 32'h3FFFF);
      nxt();
      wr_req = 1'b1; wr_addr = 18'h00100; wr_data = 16'h0100;
      nxt(6);
      wr_req = 1'b0;
      chk("t6_last_sat", 32'(last_addr), 32'h3FFFF);
      nxt();

      // Reset in the middle of a write pulse.
      wr_req = 1'b1; wr_addr = 18'h00200; wr_data = 16'h0200;
      nxt(2);
      chk("t6_pre_rst_we", 32'(SRAM_WE_N), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_we",    32'(SRAM_WE_N), 32'd1);
      chk("t6_rst_oe",    32'(SRAM_OE_N), 32'd0);
      chk("t6_rst_last",  32'(last_addr), 32'd0);
      chk("t6_rst_flags", {28'd0, play_done, rd_collision, wr_overflow, busy}, 32'd0);
      wr_req = 1'b0;
      nxt(2);
      rst_n = 1'b1;
      nxt(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
